div_sched: RTL and testbench
============================

# div_sched

Sequencing controller and two-port arbiter for the shared iterative divider in the processor. It accepts divide requests from two requesters, grants the unit round-robin and drives the unit's operands and start pulse. It waits for the unit's result-ready flag, with a timeout, and returns result, exception and tag through a valid/ready response port. Divide-by-zero is resolved locally without occupying the unit.

## Interface
- TAG_W, 5: request tag width (destination register index).
- TIMEOUT, 40: maximum WAIT cycles before abort; must be ≥ unit latency + 2.
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low; all state clears while low.
- req0_valid / req1_valid  in  1  request valid.
- req0_a, req0_b / req1_a, req1_b  in  32  dividend, divisor (signed two's complement; passed through untouched).
- req0_tag / req1_tag  in  TAG_W  opaque tag, returned with the result.
- req0_ready / req1_ready  out  1  request accepted when valid && ready at a rising edge.
- rsp_valid  out  1  response valid.
- rsp_result  out  32  quotient; 0 on any exception.
- rsp_exception  out  1  unit exception, divide-by-zero or timeout.
- rsp_tag  out  TAG_W  tag of the completed request.
- rsp_port  out  1  originating port.
- rsp_ready  in  1  consumer accepts the response.
- unit_operandA, unit_operandB  out  32  operands to the divider.
- unit_start  out  1  one-cycle restart pulse to the divider.
- unit_result  in  32  divider quotient.
- unit_exception  in  1  divider exception.
- unit_resultRDY  in  1  divider done.
- busy  out  1  state ≠ IDLE.

## Operation
- States: IDLE, START, WAIT, RESP.
- IDLE: grant = the valid port. If both ports are valid, grant = !last_grant. req_k_ready = (state==IDLE) && grant==k; it is combinational, and at most one ready is high.
- On acceptance:
  - Latch a, b, tag and port.
  - Set last_grant = port.
  - If b==0: go to RESP with result 0, exception 1; the unit is not started.
  - Otherwise: go to START.
- START: unit_start=1 for exactly one cycle; clear cycle counter; go to WAIT.
- WAIT: counter increments each cycle.
  - unit_resultRDY=1: capture unit_result and unit_exception; go to RESP.
  - Counter reaches TIMEOUT-1 without RDY: result 0, exception 1; go to RESP.
  - RDY has priority over timeout in the same cycle.
- RESP: rsp_valid=1; result, exception, tag and port are held stable. On rsp_ready, go to IDLE. No new request is accepted in the RESP cycle.
- unit_operandA/B are driven from the latched operands from START through WAIT; they are 0 in IDLE.
- The divider must deassert resultRDY by the cycle after unit_start. RDY is sampled only in WAIT, never in START or IDLE.
- reset low (any state, including mid-WAIT):
  - state=IDLE, last_grant=1 (port 0 wins the first tie).
  - All outputs 0, counter 0, latched operands 0.
  - An in-flight operation is dropped without a response.
  - A stale unit_resultRDY after reset release is ignored.

## Timing
- Accept edge T: START during cycle T+1, unit_start high in T+1, WAIT from T+2.
- RDY first seen high in cycle W: rsp_valid high from W+1.
- Divide-by-zero: rsp_valid high in cycle T+1.
- Timeout: rsp_valid high TIMEOUT cycles after WAIT entry.
- Response handshake at edge R: IDLE in R+1; the next request can be accepted at edge R+1.
- Throughput: one operation per (unit latency + 3) cycles with rsp_ready held high.

## Test plan
- Port 0 requests a=21, b=3, tag=7; the unit model raises RDY 33 cycles after start → unit_start pulses once, rsp_valid with result 7, exception 0, tag 7, port 0; req0_ready low until IDLE.
- Both ports valid together (0: 100/10, 1: −9/3), then both kept valid → port 0 served first (10), then port 1 (−3); grants alternate 0,1,0,1 across four operations.
- Port 1 request with b=0 → rsp_valid one cycle after acceptance with result 0, exception 1; unit_start never asserts.
- Unit model never raises RDY, TIMEOUT=40 → rsp_valid exactly 40 cycles after WAIT entry with result 0, exception 1; next request then completes normally.
- rsp_ready held low 5 cycles in RESP → rsp_* stable, both req_ready low; release → IDLE the next cycle.
- reset pulled low mid-WAIT → all outputs 0 asynchronously, no response emitted; after release, a tie is won by port 0.

Source files
------------

// File: rtl/div_sched_if.sv
// rtl/div_sched_if.sv - request, response and divider-unit signal bundle for div_sched
interface div_sched_if #(
    parameter int TAG_W = 5
);
    logic             req0_valid;
    logic             req0_ready;
    logic [31:0]      req0_a;
    logic [31:0]      req0_b;
    logic [TAG_W-1:0] req0_tag;
    logic             req1_valid;
    logic             req1_ready;
    logic [31:0]      req1_a;
    logic [31:0]      req1_b;
    logic [TAG_W-1:0] req1_tag;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [31:0]      rsp_result;
    logic             rsp_exception;
    logic [TAG_W-1:0] rsp_tag;
    logic             rsp_port;
    logic [31:0]      unit_operandA;
    logic [31:0]      unit_operandB;
    logic             unit_start;
    logic [31:0]      unit_result;
    logic             unit_exception;
    logic             unit_resultRDY;
    logic             busy;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_tag,
        input  req1_valid, req1_a, req1_b, req1_tag,
        input  rsp_ready, unit_result, unit_exception, unit_resultRDY,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_result, rsp_exception, rsp_tag, rsp_port,
        output unit_operandA, unit_operandB, unit_start, busy
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_tag,
        output req1_valid, req1_a, req1_b, req1_tag,
        output rsp_ready, unit_result, unit_exception, unit_resultRDY,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_result, rsp_exception, rsp_tag, rsp_port,
        input  unit_operandA, unit_operandB, unit_start, busy
    );
endinterface

// File: rtl/div_sched.sv
// rtl/div_sched.sv - round-robin two-port scheduler and sequencer for the shared iterative divider
module div_sched #(
    parameter int TAG_W   = 5,
    parameter int TIMEOUT = 40
) (
    input  logic        clock,
    input  logic        reset,
    div_sched_if.slave  bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [1:0]       state;
    logic             last_grant;
    logic             grant;
    logic             idle_open;
    logic             accept;
    logic [31:0]      sel_a;
    logic [31:0]      sel_b;
    logic [TAG_W-1:0] sel_tag;
    logic [31:0]      a_q;
    logic [31:0]      b_q;
    logic [TAG_W-1:0] tag_q;
    logic             port_q;
    logic [31:0]      res_q;
    logic             exc_q;
    logic [CNT_W-1:0] cnt;
    logic             unit_active;

    always_comb begin
        grant = 1'b0;
        if (bus.req0_valid && bus.req1_valid)
            grant = ~last_grant;
        else if (bus.req1_valid)
            grant = 1'b1;
    end

    // Readies are gated by reset so every output reads 0 while reset is held.
    assign idle_open      = reset && (state == S_IDLE);
    assign bus.req0_ready = idle_open && !grant;
    assign bus.req1_ready = idle_open && grant;
    assign accept         = (bus.req0_valid && bus.req0_ready) ||
                            (bus.req1_valid && bus.req1_ready);

    assign sel_a   = grant ? bus.req1_a   : bus.req0_a;
    assign sel_b   = grant ? bus.req1_b   : bus.req0_b;
    assign sel_tag = grant ? bus.req1_tag : bus.req0_tag;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            last_grant <= 1'b1;
            a_q        <= '0;
            b_q        <= '0;
            tag_q      <= '0;
            port_q     <= 1'b0;
            res_q      <= '0;
            exc_q      <= 1'b0;
            cnt        <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        a_q        <= sel_a;
                        b_q        <= sel_b;
                        tag_q      <= sel_tag;
                        port_q     <= grant;
                        last_grant <= grant;
                        cnt        <= '0;
                        // Divide-by-zero never reaches the unit.
                        if (sel_b == 32'd0) begin
                            res_q <= '0;
                            exc_q <= 1'b1;
                            state <= S_RESP;
                        end else begin
                            state <= S_START;
                        end
                    end
                end
                S_START: begin
                    cnt   <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    // A result arriving on the timeout cycle still wins.
                    if (bus.unit_resultRDY) begin
                        res_q <= bus.unit_exception ? 32'd0 : bus.unit_result;
                        exc_q <= bus.unit_exception;
                        state <= S_RESP;
                    end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                        res_q <= '0;
                        exc_q <= 1'b1;
                        state <= S_RESP;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_RESP: begin
                    if (bus.rsp_ready)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign unit_active       = (state == S_START) || (state == S_WAIT);
    assign bus.unit_operandA = unit_active ? a_q : 32'd0;
    assign bus.unit_operandB = unit_active ? b_q : 32'd0;
    assign bus.unit_start    = (state == S_START);
    assign bus.rsp_valid     = (state == S_RESP);
    assign bus.rsp_result    = res_q;
    assign bus.rsp_exception = exc_q;
    assign bus.rsp_tag       = tag_q;
    assign bus.rsp_port      = port_q;
    assign bus.busy          = (state != S_IDLE);
endmodule

// File: tb/tb_div_sched.sv
// tb/tb_div_sched.sv - randomized and directed self-checking bench for div_sched
module tb_div_sched;
    localparam int TAG_W   = 5;
    localparam int TIMEOUT = 40;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    div_sched_if #(.TAG_W(TAG_W)) bus ();

    div_sched #(.TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int               n_vec = 0;
    int               n_err = 0;
    bit               last_g;
    bit               pv [2];
    logic [31:0]      pa [2];
    logic [31:0]      pb [2];
    logic [TAG_W-1:0] pt [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_ports();
        bus.req0_valid = pv[0];
        bus.req0_a     = pa[0];
        bus.req0_b     = pb[0];
        bus.req0_tag   = pt[0];
        bus.req1_valid = pv[1];
        bus.req1_a     = pa[1];
        bus.req1_b     = pb[1];
        bus.req1_tag   = pt[1];
    endtask

    task automatic set_req(input int p, input logic [31:0] a, input logic [31:0] b, input int t);
        pv[p] = 1'b1;
        pa[p] = a;
        pb[p] = b;
        pt[p] = TAG_W'(t);
    endtask

    task automatic rand_req(input int p);
        logic [15:0] a16;
        int          bi;
        a16 = 16'($urandom);
        bi  = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 200) - 100;
        set_req(p, {{16{a16[15]}}, a16}, 32'(bi), $urandom_range(0, 31));
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_r0"},  bus.req0_ready, 0);
        chk({tag, "_r1"},  bus.req1_ready, 0);
        chk({tag, "_rv"},  bus.rsp_valid, 0);
        chk({tag, "_res"}, bus.rsp_result, 0);
        chk({tag, "_exc"}, bus.rsp_exception, 0);
        chk({tag, "_tag"}, 32'(bus.rsp_tag), 0);
        chk({tag, "_prt"}, bus.rsp_port, 0);
        chk({tag, "_opa"}, bus.unit_operandA, 0);
        chk({tag, "_opb"}, bus.unit_operandB, 0);
        chk({tag, "_st"},  bus.unit_start, 0);
        chk({tag, "_bsy"}, bus.busy, 0);
    endtask

    // One operation from the IDLE cycle (ports already driven at this negedge)
    // through response handshake; lat==0 means the unit never answers.
    task automatic run_op(input int lat, input bit uexc, input int stall, output int gp);
        int                g;
        int                cyc;
        logic signed [31:0] sa, sb, q;
        logic [31:0]       exp_res;
        logic              exp_exc;
        logic [TAG_W-1:0]  t;
        #1;
        g = (pv[0] && pv[1]) ? int'(!last_g) : int'(pv[1]);
        gp = g;
        chk("req0_ready", bus.req0_ready, (g == 0));
        chk("req1_ready", bus.req1_ready, (g == 1));
        chk("busy_idle", bus.busy, 0);
        sa = pa[g];
        sb = pb[g];
        t  = pt[g];
        last_g = g[0];
        @(posedge clock);
        @(negedge clock);
        pv[g] = 1'b0;
        drive_ports();
        bus.unit_resultRDY = 1'b0;
        chk("ready_after_acc", {bus.req0_ready, bus.req1_ready}, 0);
        if (sb == 0) begin
            chk("dz_no_start", bus.unit_start, 0);
            exp_res = 0;
            exp_exc = 1'b1;
        end else begin
            chk("unit_start", bus.unit_start, 1);
            chk("operand_a", bus.unit_operandA, sa);
            chk("operand_b", bus.unit_operandB, sb);
            if (lat > 0) begin
                for (int k = 1; k < lat; k++) begin
                    @(negedge clock);
                    chk("wait_start", bus.unit_start, 0);
                    chk("wait_rsp", bus.rsp_valid, 0);
                    chk("wait_ready", {bus.req0_ready, bus.req1_ready}, 0);
                end
                @(negedge clock);
                q = uexc ? 32'hdead_beef : sa / sb;
                bus.unit_result    = q;
                bus.unit_exception = uexc;
                bus.unit_resultRDY = 1'b1;
                @(negedge clock);
                bus.unit_resultRDY = 1'b0;
                bus.unit_result    = 32'h0bad_0bad;
                exp_res = uexc ? 32'd0 : q;
                exp_exc = uexc;
            end else begin
                cyc = 0;
                do begin
                    @(negedge clock);
                    cyc++;
                end while (!bus.rsp_valid && cyc < 200);
                chk("timeout_cycles", cyc, TIMEOUT + 1);
                exp_res = 0;
                exp_exc = 1'b1;
            end
        end
        for (int s = 0; s <= stall; s++) begin
            if (s > 0) @(negedge clock);
            chk("rsp_valid", bus.rsp_valid, 1);
            chk("rsp_result", bus.rsp_result, exp_res);
            chk("rsp_exception", bus.rsp_exception, exp_exc);
            chk("rsp_tag", 32'(bus.rsp_tag), 32'(t));
            chk("rsp_port", bus.rsp_port, g);
            chk("resp_ready", {bus.req0_ready, bus.req1_ready}, 0);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        bus.rsp_ready = 1'b0;
        chk("idle_after", bus.busy, 0);
        chk("rsp_drop", bus.rsp_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int gp;
        pv[0] = 0; pv[1] = 0;
        pa[0] = 0; pa[1] = 0; pb[0] = 0; pb[1] = 0; pt[0] = 0; pt[1] = 0;
        drive_ports();
        bus.rsp_ready      = 1'b0;
        bus.unit_result    = 32'd0;
        bus.unit_exception = 1'b0;
        bus.unit_resultRDY = 1'b0;
        last_g = 1'b1;

        // Reset state, with both ports requesting.
        set_req(0, 32'd1, 32'd1, 1);
        set_req(1, 32'd2, 32'd2, 2);
        drive_ports();
        #22;
        check_all_zero("reset");
        @(negedge clock);
        reset = 1'b1;

        // Tie then sustained contention: grants alternate starting at port 0.
        set_req(0, 32'd100, 32'd10, 3);
        set_req(1, -32'sd9, 32'd3, 12);
        drive_ports();
        for (int i = 0; i < 4; i++) begin
            run_op(10 + i, 1'b0, 0, gp);
            chk("alternate", gp, i % 2);
            rand_req(gp);
            if (pb[gp] == 0) pb[gp] = 32'd7;
            drive_ports();
        end

        // Single request, unit answers 33 cycles after start.
        pv[1] = 0;
        set_req(0, 32'd21, 32'd3, 7);
        drive_ports();
        run_op(33, 1'b0, 0, gp);

        // Divide-by-zero on port 1.
        set_req(1, 32'd55, 32'd0, 9);
        drive_ports();
        run_op(5, 1'b0, 0, gp);

        // Unit never answers, then a normal operation.
        set_req(0, 32'd77, 32'd5, 4);
        drive_ports();
        run_op(0, 1'b0, 0, gp);
        set_req(0, -32'sd50, 32'd7, 5);
        drive_ports();
        run_op(6, 1'b0, 0, gp);

        // Consumer stalls five cycles in RESP.
        set_req(1, 32'd90, -32'sd9, 22);
        drive_ports();
        run_op(8, 1'b0, 5, gp);

        // Reset mid-WAIT, stale RDY across release, tie afterwards.
        set_req(0, 32'd64, 32'd8, 13);
        drive_ports();
        #1;
        @(posedge clock);
        @(negedge clock);
        pv[0] = 0;
        repeat (5) @(negedge clock);
        chk("pre_reset_busy", bus.busy, 1);
        set_req(0, 32'd30, 32'd6, 17);
        set_req(1, 32'd40, 32'd4, 18);
        drive_ports();
        #2;
        reset = 1'b0;
        bus.unit_resultRDY = 1'b1;
        bus.unit_result    = 32'h1234_5678;
        #1;
        check_all_zero("mid_wait_reset");
        last_g = 1'b1;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        run_op(4, 1'b0, 0, gp);
        chk("post_reset_tie", gp, 0);

        // Randomized operations.
        for (int i = 0; i < 14; i++) begin
            if ($urandom_range(0, 1) == 1) rand_req(0);
            if ($urandom_range(0, 1) == 1) rand_req(1);
            if (!pv[0] && !pv[1]) rand_req($urandom_range(0, 1));
            drive_ports();
            run_op(($urandom_range(0, 9) == 0) ? 0 : $urandom_range(2, 36),
                   ($urandom_range(0, 7) == 0), $urandom_range(0, 2), gp);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
